// File: rtl/dispatcher_iter_ctrl.sv
// Job sequencer gating act/weight handshakes into the DISPACHER; zero-latency combinational gates, upstream stalls whenever a gate is closed.
// Optional perf counters behind DISPATCH_CTRL_PERF_EN.
module dispatcher_iter_ctrl #(
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int DRAIN_CYCLES           = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LOG_MAX_ITERS-1:0]          cfg_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] cfg_num_reads,
  output logic                              busy,
  output logic                              done,
  output logic                              disp_configure,
  output logic [LOG_MAX_ITERS-1:0]          disp_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] disp_num_reads,
  input  logic                              src_act_valid_in,
  output logic                              src_act_avail_out,
  output logic                              disp_act_valid_out,
  input  logic                              disp_act_avail_in,
  input  logic                              src_w_valid_in,
  output logic                              src_w_avail_out,
  output logic                              disp_w_valid_out,
  input  logic                              disp_w_avail_in,
  input  logic                              disp_valid_in
`ifdef DISPATCH_CTRL_PERF_EN
  ,
  output logic [31:0]                       perf_run_cycles,
  output logic [31:0]                       perf_act_stall
`endif
);

  localparam int QW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                            state, state_nxt;
  logic [LOG_MAX_ITERS-1:0]          num_iters, iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads, read_cnt;
  logic                              reads_done, w_taken;
  logic [QW-1:0]                     quiet_cnt;

  logic run, act_open, w_open, act_beat, w_beat, final_act, iter_end, last_iter, quiet_hit, zero_job;

  assign run       = (state == S_RUN);
  assign act_open  = run & ~reads_done;
  assign w_open    = run & ~w_taken;
  assign act_beat  = src_act_valid_in & disp_act_avail_in & act_open;
  assign w_beat    = src_w_valid_in & disp_w_avail_in & w_open;
  assign final_act = act_beat & (read_cnt == num_reads - LOG_MAX_READS_PER_ITER'(1));
  // Weight and reads may complete in either order or together.
  assign iter_end  = (reads_done | final_act) & (w_taken | w_beat);
  assign last_iter = (iter_cnt == num_iters - LOG_MAX_ITERS'(1));
  assign quiet_hit = ~disp_valid_in & (quiet_cnt == QW'(DRAIN_CYCLES - 1));
  assign zero_job  = (num_iters == '0) | (num_reads == '0);

  assign src_act_avail_out  = disp_act_avail_in & act_open;
  assign disp_act_valid_out = src_act_valid_in & act_open;
  assign src_w_avail_out    = disp_w_avail_in & w_open;
  assign disp_w_valid_out   = src_w_valid_in & w_open;
  assign disp_num_iters     = num_iters;
  assign disp_num_reads     = num_reads;

  always_comb begin
    state_nxt      = state;
    busy           = 1'b1;
    done           = 1'b0;
    disp_configure = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CONFIG;
      end
      S_CONFIG: begin
        disp_configure = 1'b1;
        state_nxt      = zero_job ? S_DONE : S_RUN;
      end
      S_RUN:   if (iter_end && last_iter) state_nxt = S_DRAIN;
      S_DRAIN: if (quiet_hit) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      num_iters  <= '0;
      num_reads  <= '0;
      iter_cnt   <= '0;
      read_cnt   <= '0;
      reads_done <= 1'b0;
      w_taken    <= 1'b0;
      quiet_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          num_iters <= cfg_num_iters;
          num_reads <= cfg_num_reads;
        end
        S_CONFIG: begin
          iter_cnt   <= '0;
          read_cnt   <= '0;
          reads_done <= 1'b0;
          w_taken    <= 1'b0;
          quiet_cnt  <= '0;
        end
        S_RUN: begin
          if (act_beat) begin
            if (final_act) begin
              read_cnt   <= '0;
              reads_done <= 1'b1;
            end else begin
              read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
            end
          end
          if (w_beat) w_taken <= 1'b1;
          // Iteration close overrides the per-beat flag sets above.
          if (iter_end) begin
            reads_done <= 1'b0;
            w_taken    <= 1'b0;
            iter_cnt   <= iter_cnt + LOG_MAX_ITERS'(1);
            quiet_cnt  <= '0;
          end
        end
        S_DRAIN: quiet_cnt <= disp_valid_in ? '0 : quiet_cnt + QW'(1);
        default: ;
      endcase
    end
  end

`ifdef DISPATCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst || (state == S_IDLE && start)) begin
      perf_run_cycles <= '0;
      perf_act_stall  <= '0;
    end else begin
      if (run && ~&perf_run_cycles) perf_run_cycles <= perf_run_cycles + 32'd1;
      if (act_open && src_act_valid_in && !disp_act_avail_in && ~&perf_act_stall)
        perf_act_stall <= perf_act_stall + 32'd1;
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_dispatcher_iter_ctrl.sv
// Directed bench for dispatcher_iter_ctrl: expected handshake events are queued with their cycle stamps and
// checked by an independent monitor.
module tb_dispatcher_iter_ctrl;
  localparam int LI = 16;
  localparam int LR = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [LI-1:0] cfg_num_iters, disp_num_iters;
  logic [LR-1:0] cfg_num_reads, disp_num_reads;
  logic          busy, done, disp_configure;
  logic          src_act_valid_in, src_act_avail_out, disp_act_valid_out, disp_act_avail_in;
  logic          src_w_valid_in, src_w_avail_out, disp_w_valid_out, disp_w_avail_in;
  logic          disp_valid_in;
`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0]   perf_run_cycles, perf_act_stall;
`endif

  dispatcher_iter_ctrl #(.LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR), .DRAIN_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_iters(cfg_num_iters), .cfg_num_reads(cfg_num_reads),
    .busy(busy), .done(done), .disp_configure(disp_configure),
    .disp_num_iters(disp_num_iters), .disp_num_reads(disp_num_reads),
    .src_act_valid_in(src_act_valid_in), .src_act_avail_out(src_act_avail_out),
    .disp_act_valid_out(disp_act_valid_out), .disp_act_avail_in(disp_act_avail_in),
    .src_w_valid_in(src_w_valid_in), .src_w_avail_out(src_w_avail_out),
    .disp_w_valid_out(disp_w_valid_out), .disp_w_avail_in(disp_w_avail_in),
    .disp_valid_in(disp_valid_in)
`ifdef DISPATCH_CTRL_PERF_EN
    , .perf_run_cycles(perf_run_cycles), .perf_act_stall(perf_act_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event code bits: {done, configure, act beat, weight beat}
  localparam logic [3:0] E_W = 4'b0001, E_A = 4'b0010, E_AW = 4'b0011, E_CFG = 4'b0100, E_DONE = 4'b1000;

  typedef struct {
    logic [3:0] code;
    int         at;
  } ev_t;

  ev_t        expq[$];
  ev_t        ev;
  logic [3:0] obs;
  int         checks = 0;
  int         failures = 0;
  int         base = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_ev(input logic [3:0] code, input int rel);
    ev_t e;
    e.code = code;
    e.at   = base + rel;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues start for one cycle; returns one cycle after base with junk on cfg_*.
  task automatic job_start(input int it, input int rd);
    base          = cyc;
    cfg_num_iters = LI'(it);
    cfg_num_reads = LR'(rd);
    start         = 1'b1;
    tick(1);
    start         = 1'b0;
    cfg_num_iters = 16'hbeef;
    cfg_num_reads = 16'h0abc;
  endtask

  task automatic drained(input string name);
    chk(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs = {done, disp_configure, disp_act_valid_out & disp_act_avail_in, disp_w_valid_out & disp_w_avail_in};
      if (obs != 4'b0000) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: code=%b at cycle %0d, none expected", obs, cyc);
        end else begin
          ev = expq.pop_front();
          if (ev.code !== obs || ev.at != cyc) begin
            failures++;
            $display("FAIL event: got code=%b at cycle %0d, expected code=%b at cycle %0d", obs, cyc, ev.code, ev.at);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_num_iters = '0; cfg_num_reads = '0;
    src_act_valid_in = 1'b1; disp_act_avail_in = 1'b1;
    src_w_valid_in = 1'b1; disp_w_avail_in = 1'b1; disp_valid_in = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_configure", 32'(disp_configure), 0);
    chk("rst_act_gate", 32'({src_act_avail_out, disp_act_valid_out}), 0);
    chk("rst_w_gate", 32'({src_w_avail_out, disp_w_valid_out}), 0);
    chk("rst_num_iters", 32'(disp_num_iters), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    tick(1);

    // Basic job 2x4, everything always offered, drain holds off for valid.
    disp_valid_in = 1'b1;
    job_start(2, 4);
    exp_ev(E_CFG, 1); exp_ev(E_AW, 2); exp_ev(E_A, 3); exp_ev(E_A, 4); exp_ev(E_A, 5);
    exp_ev(E_AW, 6); exp_ev(E_A, 7); exp_ev(E_A, 8); exp_ev(E_A, 9); exp_ev(E_DONE, 21);
    tick(2);
    chk("basic_num_reads", 32'(disp_num_reads), 4);
    tick(10);
    disp_valid_in = 1'b0;
    tick(10);
    drained("basic_events");

    // Late weight: reads finish, weight withheld 5 cycles.
    src_w_valid_in = 1'b0;
    job_start(1, 4);
    exp_ev(E_CFG, 1); exp_ev(E_A, 2); exp_ev(E_A, 3); exp_ev(E_A, 4); exp_ev(E_A, 5);
    exp_ev(E_W, 11); exp_ev(E_DONE, 20);
    tick(5);
    for (int i = 0; i < 5; i++) begin
      chk("late_w_act_gate", 32'(src_act_avail_out), 0);
      tick(1);
    end
    src_w_valid_in = 1'b1;
    tick(1);
    src_w_valid_in = 1'b0;
    tick(10);
    drained("late_w_events");

    // Final act beat and weight beat coincide.
    job_start(2, 2);
    exp_ev(E_CFG, 1); exp_ev(E_A, 2); exp_ev(E_AW, 3); exp_ev(E_A, 4); exp_ev(E_AW, 5); exp_ev(E_DONE, 14);
    tick(2);
    src_w_valid_in = 1'b1;
    tick(1);
    src_w_valid_in = 1'b0;
    chk("simul_act_reopen", 32'(src_act_avail_out), 1);
    chk("simul_w_reopen", 32'(src_w_avail_out), 1);
    tick(1);
    src_w_valid_in = 1'b1;
    tick(1);
    src_w_valid_in = 1'b0;
    tick(10);
    drained("simul_events");

    // Zero jobs with sources fully offered.
    src_w_valid_in = 1'b1;
    job_start(0, 5);
    exp_ev(E_CFG, 1); exp_ev(E_DONE, 2);
    tick(1);
    chk("zero_iters_busy_done", 32'(busy), 1);
    chk("zero_iters_num_reads", 32'(disp_num_reads), 5);
    tick(1);
    chk("zero_iters_idle", 32'(busy), 0);
    tick(2);
    job_start(3, 0);
    exp_ev(E_CFG, 1); exp_ev(E_DONE, 2);
    tick(2);
    chk("zero_reads_idle", 32'(busy), 0);
    tick(2);
    drained("zero_events");

    // Reset mid-RUN after three act beats, then a clean job.
    src_w_valid_in = 1'b0;
    job_start(1, 4);
    exp_ev(E_CFG, 1); exp_ev(E_A, 2); exp_ev(E_A, 3); exp_ev(E_A, 4);
    tick(4);
    rst = 1'b0;
    src_act_valid_in = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_num_iters", 32'(disp_num_iters), 0);
    chk("midrst_num_reads", 32'(disp_num_reads), 0);
    chk("midrst_w_gate", 32'(src_w_avail_out), 0);
    tick(15);
    drained("midrst_events");
    src_act_valid_in = 1'b1;
    src_w_valid_in = 1'b1;
    job_start(1, 2);
    exp_ev(E_CFG, 1); exp_ev(E_AW, 2); exp_ev(E_A, 3); exp_ev(E_DONE, 12);
    tick(13);
    drained("post_rst_events");

    // Start while busy, act backpressure toggling.
    disp_act_avail_in = 1'b0;
    job_start(1, 3);
    exp_ev(E_CFG, 1); exp_ev(E_W, 2); exp_ev(E_A, 3); exp_ev(E_A, 5); exp_ev(E_A, 7); exp_ev(E_DONE, 16);
    for (int i = 2; i <= 7; i++) begin
      tick(1);
      disp_act_avail_in = (i % 2 == 1);
      start = (i == 4);
      if (i == 4) begin
        cfg_num_iters = 16'd5;
        cfg_num_reads = 16'd9;
      end
      if (i == 6) begin
        chk("busy_start_num_reads", 32'(disp_num_reads), 3);
        chk("busy_start_num_iters", 32'(disp_num_iters), 1);
      end
    end
    start = 1'b0;
    disp_act_avail_in = 1'b1;
    tick(10);
    drained("busy_start_events");
`ifdef DISPATCH_CTRL_PERF_EN
    chk("perf_run_cycles", perf_run_cycles, 6);
    chk("perf_act_stall", perf_act_stall, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
